// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs a single-outstanding req/ack
// fetch to instruction memory and buffers returned words in a prefetch queue for decode.
module if_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [31:0]                imem_data_i,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                pc_plus4_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc, fetch_pc_nxt;
  logic [31:0]     drain_addr;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic            valid, push, pop, room;
  logic [31:0]     redirect_tgt;
  logic            unused_pc_lsbs;

  assign redirect_tgt   = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_lsbs = &{1'b0, redirect_pc_i[1:0]};

  assign valid = (count != '0);
  assign pop   = valid && !stall_i && !redirect_i;
  assign push  = (state == REQ) && imem_ack_i && !redirect_i;

  // Flush wins over push and pop.
  always_comb begin
    count_nxt = count;
    if (redirect_i)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  assign room = (count_nxt < CW'(DEPTH));

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_tgt;
          state_nxt    = REQ;
        end else if (room) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_tgt;
          state_nxt    = imem_ack_i ? REQ : DRAIN;
        end else if (imem_ack_i) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = room ? REQ : IDLE;
        end
      end
      DRAIN: begin
        // The stale request must complete before the new target can go out.
        if (redirect_i)
          fetch_pc_nxt = redirect_tgt;
        if (imem_ack_i)
          state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= imem_data_i;
    end
    if (state == REQ && redirect_i && !imem_ack_i)
      drain_addr <= fetch_pc;
  end

  assign imem_req_o  = (state != IDLE);
  assign imem_addr_o = (state == DRAIN) ? drain_addr : fetch_pc;
  assign valid_o     = valid;
  assign count_o     = count;
  assign instr_o     = valid ? q_instr[rd_ptr] : 32'h0;
  assign pc_o        = valid ? q_pc[rd_ptr] : 32'h0;
  assign pc_plus4_o  = valid ? (q_pc[rd_ptr] + 32'd4) : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table with a hand-driven memory,
// then sequences against an auto-acking memory model with programmable wait states.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] instr_o, pc_o, pc_plus4_o;
  logic        valid_o;
  logic [2:0]  count_o;

  if_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .valid_o(valid_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: either hand-driven (man_mode) or acks after lat_cfg extra wait cycles.
  logic        man_mode = 1'b1;
  logic        man_ack  = 1'b0;
  logic [31:0] man_data = 32'h0;
  int          lat_cfg  = 0;
  int          wait_cnt;
  logic        auto_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign auto_ack    = imem_req_o && (wait_cnt == lat_cfg);
  assign imem_ack_i  = man_mode ? man_ack : auto_ack;
  assign imem_data_i = man_mode ? man_data : mem_word(imem_addr_o);

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                         wait_cnt <= 0;
    else if (!imem_req_o || imem_ack_i) wait_cnt <= 0;
    else                                wait_cnt <= wait_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    man_mode = 1'b1; man_ack = 1'b0; man_data = 32'h0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  cnt;
  } vec_t;

  localparam logic [31:0] I0 = 32'h1111_0000, I1 = 32'h1111_0004;
  localparam logic [31:0] I2 = 32'h2222_0300, I3 = 32'h2222_0304;
  localparam logic [31:0] I4 = 32'h4444_0200, I5 = 32'h4444_0204;
  localparam logic [31:0] I6 = 32'h4444_0208, I7 = 32'h4444_020C;
  localparam logic [31:0] I8 = 32'h8888_0210;
  localparam logic [31:0] BAD0 = 32'hBAD0_0008, BAD1 = 32'hBAD1_0308;

  vec_t tbl [24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          run;
    int          runs_seen;
    int          max_cnt;
    bit          have;
    logic [31:0] pa;

    // Inputs applied for the next edge; expected outputs as seen before that edge.
    //          ack  data  stl red rpc            req addr        vld pc          instr cnt
    tbl[0]  = '{0, 32'h0, 0, 0, 32'h0,         0, 32'h0,       0, 32'h0,       32'h0, 3'd0};
    tbl[1]  = '{1, I0,    0, 0, 32'h0,         1, 32'h0,       0, 32'h0,       32'h0, 3'd0};
    tbl[2]  = '{0, 32'h0, 1, 0, 32'h0,         1, 32'h4,       1, 32'h0,       I0,    3'd1};
    tbl[3]  = '{1, I1,    1, 0, 32'h0,         1, 32'h4,       1, 32'h0,       I0,    3'd1};
    tbl[4]  = '{0, 32'h0, 0, 0, 32'h0,         1, 32'h8,       1, 32'h0,       I0,    3'd2};
    tbl[5]  = '{0, 32'h0, 1, 1, 32'h100,       1, 32'h8,       1, 32'h4,       I1,    3'd1};
    tbl[6]  = '{0, 32'h0, 0, 0, 32'h0,         1, 32'h8,       0, 32'h0,       32'h0, 3'd0};
    tbl[7]  = '{0, 32'h0, 0, 1, 32'h303,       1, 32'h8,       0, 32'h0,       32'h0, 3'd0};
    tbl[8]  = '{1, BAD0,  0, 0, 32'h0,         1, 32'h8,       0, 32'h0,       32'h0, 3'd0};
    tbl[9]  = '{1, I2,    0, 0, 32'h0,         1, 32'h300,     0, 32'h0,       32'h0, 3'd0};
    tbl[10] = '{1, I3,    1, 0, 32'h0,         1, 32'h304,     1, 32'h300,     I2,    3'd1};
    tbl[11] = '{1, BAD1,  0, 1, 32'h200,       1, 32'h308,     1, 32'h300,     I2,    3'd2};
    tbl[12] = '{1, I4,    1, 0, 32'h0,         1, 32'h200,     0, 32'h0,       32'h0, 3'd0};
    tbl[13] = '{1, I5,    1, 0, 32'h0,         1, 32'h204,     1, 32'h200,     I4,    3'd1};
    tbl[14] = '{1, I6,    1, 0, 32'h0,         1, 32'h208,     1, 32'h200,     I4,    3'd2};
    tbl[15] = '{1, I7,    1, 0, 32'h0,         1, 32'h20C,     1, 32'h200,     I4,    3'd3};
    tbl[16] = '{0, 32'h0, 1, 0, 32'h0,         0, 32'h210,     1, 32'h200,     I4,    3'd4};
    tbl[17] = '{0, 32'h0, 0, 0, 32'h0,         0, 32'h210,     1, 32'h200,     I4,    3'd4};
    tbl[18] = '{1, I8,    0, 0, 32'h0,         1, 32'h210,     1, 32'h204,     I5,    3'd3};
    tbl[19] = '{0, 32'h0, 0, 0, 32'h0,         1, 32'h214,     1, 32'h208,     I6,    3'd3};
    tbl[20] = '{0, 32'h0, 0, 0, 32'h0,         1, 32'h214,     1, 32'h20C,     I7,    3'd2};
    tbl[21] = '{0, 32'h0, 0, 0, 32'h0,         1, 32'h214,     1, 32'h210,     I8,    3'd1};
    tbl[22] = '{0, 32'h0, 1, 0, 32'h0,         1, 32'h214,     0, 32'h0,       32'h0, 3'd0};
    tbl[23] = '{0, 32'h0, 0, 0, 32'h0,         1, 32'h214,     0, 32'h0,       32'h0, 3'd0};

    // Reset state while rst_n is held low
    rst_n = 1'b0;
    @(negedge clk_i);
    chk("rst.req",   32'(imem_req_o), 32'h0);
    chk("rst.count", 32'(count_o),    32'h0);
    chk("rst.valid", 32'(valid_o),    32'h0);
    chk("rst.addr",  imem_addr_o,     32'h0);
    chk("rst.instr", instr_o,         32'h0);
    chk("rst.pc",    pc_o,            32'h0);
    chk("rst.pc4",   pc_plus4_o,      32'h0);

    // Cycle-by-cycle table with hand-driven memory
    do_reset();
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("v%0d.req", i),   32'(imem_req_o), 32'(tbl[i].req));
      chk($sformatf("v%0d.addr", i),  imem_addr_o,     tbl[i].addr);
      chk($sformatf("v%0d.valid", i), 32'(valid_o),    32'(tbl[i].valid));
      chk($sformatf("v%0d.pc", i),    pc_o,            tbl[i].pc);
      chk($sformatf("v%0d.pc4", i),   pc_plus4_o,      tbl[i].valid ? tbl[i].pc + 32'd4 : 32'h0);
      chk($sformatf("v%0d.instr", i), instr_o,         tbl[i].instr);
      chk($sformatf("v%0d.count", i), 32'(count_o),    32'(tbl[i].cnt));
      man_ack = tbl[i].ack; man_data = tbl[i].data; stall_i = tbl[i].stall;
      redirect_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc;
      @(negedge clk_i);
    end

    // Zero-wait memory, no stall: one instruction per cycle
    do_reset();
    man_mode = 1'b0; lat_cfg = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk_i);
      chk($sformatf("zw%0d.req", n),  32'(imem_req_o), 32'h1);
      chk($sformatf("zw%0d.addr", n), imem_addr_o, 32'(4 * (n - 1)));
      if (n == 1) begin
        chk("zw1.valid", 32'(valid_o), 32'h0);
      end else begin
        chk($sformatf("zw%0d.valid", n), 32'(valid_o), 32'h1);
        chk($sformatf("zw%0d.pc", n),    pc_o, 32'(4 * (n - 2)));
        chk($sformatf("zw%0d.pc4", n),   pc_plus4_o, 32'(4 * (n - 1)));
        chk($sformatf("zw%0d.instr", n), instr_o, mem_word(32'(4 * (n - 2))));
        chk($sformatf("zw%0d.count", n), 32'(count_o), 32'h1);
      end
    end

    // Stall held with zero-wait memory: fills to DEPTH, then drains in order
    do_reset();
    man_mode = 1'b0; lat_cfg = 0; stall_i = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("full.count", 32'(count_o),    32'h4);
    chk("full.req",   32'(imem_req_o), 32'h0);
    chk("full.addr",  imem_addr_o,     32'h10);
    for (int i = 0; i <= 4; i++) begin
      chk($sformatf("drain%0d.pc", i),    pc_o, 32'(4 * i));
      chk($sformatf("drain%0d.instr", i), instr_o, mem_word(32'(4 * i)));
      if (i == 1) begin
        chk("drain1.req",  32'(imem_req_o), 32'h1);
        chk("drain1.addr", imem_addr_o,     32'h10);
      end
      stall_i = 1'b0;
      @(negedge clk_i);
    end

    // Three-cycle memory latency with stall: each request held 3 cycles
    do_reset();
    man_mode = 1'b0; lat_cfg = 2; stall_i = 1'b1;
    run = 0; runs_seen = 0; max_cnt = 0; have = 1'b0; pa = 32'h0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk_i);
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      if (imem_req_o) begin
        if (have && imem_addr_o == pa) begin
          run++;
        end else begin
          if (have) begin
            chk($sformatf("lat3.run@%h", pa), 32'(run), 32'd3);
            runs_seen++;
          end
          pa = imem_addr_o; run = 1; have = 1'b1;
        end
      end else if (have) begin
        chk($sformatf("lat3.run@%h", pa), 32'(run), 32'd3);
        runs_seen++;
        have = 1'b0;
      end
    end
    chk("lat3.runs",    32'(runs_seen), 32'd4);
    chk("lat3.maxcnt",  32'(max_cnt),   32'd4);
    chk("lat3.req_end", 32'(imem_req_o), 32'h0);

    // Redirect with ack to the last word address, then 32-bit wrap
    do_reset();
    man_mode = 1'b0; lat_cfg = 0;
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk_i);
    redirect_i = 1'b0;
    chk("wrap.addr0", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap.valid0", 32'(valid_o), 32'h0);
    @(negedge clk_i);
    chk("wrap.addr1", imem_addr_o, 32'h0);
    chk("wrap.pc",    pc_o,        32'hFFFF_FFFC);
    chk("wrap.pc4",   pc_plus4_o,  32'h0);
    chk("wrap.instr", instr_o,     mem_word(32'hFFFF_FFFC));

    // Reset asserted mid-request clears state immediately
    stall_i = 1'b1; lat_cfg = 7;
    repeat (3) @(negedge clk_i);
    chk("mid.req_pre",   32'(imem_req_o), 32'h1);
    chk("mid.count_pre", 32'(count_o),    32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.req",   32'(imem_req_o), 32'h0);
    chk("mid.count", 32'(count_o),    32'h0);
    chk("mid.valid", 32'(valid_o),    32'h0);
    @(negedge clk_i);
    rst_n = 1'b1; stall_i = 1'b0; lat_cfg = 0;
    @(negedge clk_i);
    chk("mid.req_post",  32'(imem_req_o), 32'h1);
    chk("mid.addr_post", imem_addr_o,     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
